// File: rtl/stream_minmax_tracker.sv
// Running min/max tracker over a valid/ready packet stream of unsigned 32-bit operands.
// Emits one registered result beat (min, max, first-occurrence indices, count, overflow) per packet.

module comparator_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        gt
);
  assign eq = (a == b);
  assign lt = (a <  b);
  assign gt = (a >  b);
endmodule

module stream_minmax_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_min,
  output logic [31:0]      out_max,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [31:0]      min_q, max_q;
  logic [CNT_W-1:0] min_idx_q, max_idx_q, count_q;
  logic             ovf_q;
  logic             accept;

  logic min_eq, min_lt, min_gt;
  logic max_eq, max_lt, max_gt;

  comparator_32b u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .eq (min_eq),
    .lt (min_lt),
    .gt (min_gt)
  );

  comparator_32b u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .eq (max_eq),
    .lt (max_lt),
    .gt (max_gt)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DONE : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is also masked by rst so it reads 0 throughout the reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: in_ready  = ~rst;
      DONE:        out_valid = 1'b1;
      default:     ;
    endcase
  end

  // Once saturated the count holds, so later updates record the saturated value as index.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        min_q     <= in_data;
        max_q     <= in_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
        count_q   <= CNT_ONE;
        ovf_q     <= 1'b0;
      end else begin
        if (min_lt) begin
          min_q     <= in_data;
          min_idx_q <= count_q;
        end
        if (max_gt) begin
          max_q     <= in_data;
          max_idx_q <= count_q;
        end
        if (count_q == CNT_MAX) ovf_q   <= 1'b1;
        else                    count_q <= count_q + CNT_ONE;
      end
    end
  end

  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
  assign out_count   = count_q;
  assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed bench for stream_minmax_tracker: default CNT_W=16 instance plus a CNT_W=2
// instance for saturation, both checked against hand-computed results.

module tb_stream_minmax_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: CNT_W = 16
  logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [31:0] a_out_min, a_out_max;
  logic [15:0] a_out_min_idx, a_out_max_idx, a_out_count;

  // Instance B: CNT_W = 2
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [31:0] b_out_min, b_out_max;
  logic [1:0]  b_out_min_idx, b_out_max_idx, b_out_count;

  stream_minmax_tracker #(.CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_min(a_out_min), .out_max(a_out_max),
    .out_min_idx(a_out_min_idx), .out_max_idx(a_out_max_idx),
    .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  stream_minmax_tracker #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_min(b_out_min), .out_max(b_out_max),
    .out_min_idx(b_out_min_idx), .out_max_idx(b_out_max_idx),
    .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one beat on instance sel (0=A, 1=B), wait (bounded) for in_ready, accept it.
  task automatic send(input bit sel, input logic [31:0] d, input logic last);
    logic rdy;
    @(negedge clk);
    if (sel) begin b_in_valid = 1'b1; b_in_data = d; b_in_last = last; end
    else     begin a_in_valid = 1'b1; a_in_data = d; a_in_last = last; end
    rdy = sel ? b_in_ready : a_in_ready;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      rdy = sel ? b_in_ready : a_in_ready;
    end
    chk("send_ready", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1;
    if (sel) begin b_in_valid = 1'b0; b_in_last = 1'b0; end
    else     begin a_in_valid = 1'b0; a_in_last = 1'b0; end
  endtask

  // Complete the result handshake on instance sel, then confirm return to idle.
  task automatic pop(input bit sel);
    @(negedge clk);
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (sel) b_out_ready = 1'b0; else a_out_ready = 1'b0;
    @(negedge clk);
    chk("pop_ovalid", {31'd0, sel ? b_out_valid : a_out_valid}, 32'd0);
    chk("pop_iready", {31'd0, sel ? b_in_ready  : a_in_ready},  32'd1);
  endtask

  task automatic chk_a(input string tag, input logic [31:0] mn, input int mni,
                       input logic [31:0] mx, input int mxi, input int cnt, input logic ovf);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, "_min"},   a_out_min, mn);
    chk({tag, "_minidx"}, {16'd0, a_out_min_idx}, mni);
    chk({tag, "_max"},   a_out_max, mx);
    chk({tag, "_maxidx"}, {16'd0, a_out_max_idx}, mxi);
    chk({tag, "_count"}, {16'd0, a_out_count}, cnt);
    chk({tag, "_ovf"},   {31'd0, a_out_ovf}, {31'd0, ovf});
  endtask

  initial begin
    // 1. reset
    a_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_iready", {31'd0, a_in_ready}, 32'd0);
    chk("rst_min",    a_out_min, 32'd0);
    chk("rst_count",  {16'd0, a_out_count}, 32'd0);
    chk("rst_ovf",    {31'd0, a_out_ovf}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_iready", {31'd0, a_in_ready}, 32'd1);
    chk("post_rst_ovalid", {31'd0, a_out_valid}, 32'd0);

    // 2. mixed stream with duplicates: first occurrence wins
    send(0, 32'd5, 0); send(0, 32'd3, 0); send(0, 32'd9, 0);
    send(0, 32'd3, 0); send(0, 32'd9, 1);
    chk_a("t2", 32'd3, 1, 32'd9, 2, 5, 1'b0);
    pop(0);

    // 3. single-beat packet at the top of range
    send(0, 32'hFFFF_FFFF, 1);
    chk_a("t3", 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 1, 1'b0);
    pop(0);

    // 4. unsigned ordering across the sign bit
    send(0, 32'h7FFF_FFFF, 0); send(0, 32'h8000_0000, 0); send(0, 32'd0, 1);
    chk_a("t4", 32'd0, 2, 32'h8000_0000, 1, 3, 1'b0);

    // 5. backpressure with in_valid held high
    a_in_valid = 1'b1; a_in_data = 32'd123; a_in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ovalid", {31'd0, a_out_valid}, 32'd1);
      chk("bp_iready", {31'd0, a_in_ready}, 32'd0);
      chk("bp_min",    a_out_min, 32'd0);
      chk("bp_count",  {16'd0, a_out_count}, 32'd3);
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0;
    @(negedge clk);
    chk("bp_rel_ovalid", {31'd0, a_out_valid}, 32'd0);
    chk("bp_rel_iready", {31'd0, a_in_ready}, 32'd1);
    send(0, 32'd42, 1);
    chk_a("t5", 32'd42, 0, 32'd42, 0, 1, 1'b0);
    pop(0);

    // 6. saturation on the CNT_W=2 instance
    send(1, 32'd4, 0); send(1, 32'd2, 0); send(1, 32'd7, 0);
    send(1, 32'd1, 0); send(1, 32'd0, 1);
    @(negedge clk);
    chk("t6_valid",  {31'd0, b_out_valid}, 32'd1);
    chk("t6_count",  {30'd0, b_out_count}, 32'd3);
    chk("t6_ovf",    {31'd0, b_out_ovf}, 32'd1);
    chk("t6_min",    b_out_min, 32'd0);
    chk("t6_minidx", {30'd0, b_out_min_idx}, 32'd3);
    chk("t6_max",    b_out_max, 32'd7);
    chk("t6_maxidx", {30'd0, b_out_max_idx}, 32'd2);
    pop(1);

    // reset mid-packet discards the partial result
    send(1, 32'd5, 0); send(1, 32'd6, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_ovalid", {31'd0, b_out_valid}, 32'd0);
    end
    chk("midrst_count", {30'd0, b_out_count}, 32'd0);
    send(1, 32'd6, 1);
    @(negedge clk);
    chk("t6b_valid", {31'd0, b_out_valid}, 32'd1);
    chk("t6b_min",   b_out_min, 32'd6);
    chk("t6b_max",   b_out_max, 32'd6);
    chk("t6b_count", {30'd0, b_out_count}, 32'd1);
    chk("t6b_ovf",   {31'd0, b_out_ovf}, 32'd0);
    chk("t6b_idx",   {28'd0, b_out_min_idx, b_out_max_idx}, 32'd0);
    pop(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
